// File: rtl/xon_xoff_tx_gen_pkg.sv
// Flow-control character constants and the TX generator state encoding.
// The receive-side XON/XOFF decoder shares these constants.
package flow_ctrl_pkg;

    localparam logic [7:0] XON_CHAR  = 8'h11;
    localparam logic [7:0] XOFF_CHAR = 8'h13;

    typedef enum logic [2:0] {
        INIT,
        RUN,
        SEND_XOFF,
        PAUSED,
        SEND_XON
    } fc_state_t;

endpackage

// File: rtl/xon_xoff_tx_gen_if.sv
// Byte-stream handshake bundle around the XON/XOFF generator.
// The user side is in_*; the UART side is tx_*. The generator takes the master modport.
interface xon_xoff_tx_gen_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        input  in_data, in_valid, tx_ready,
        output in_ready, tx_data, tx_valid
    );

    modport slave (
        output in_data, in_valid, tx_ready,
        input  in_ready, tx_data, tx_valid
    );

endinterface

// File: rtl/xon_xoff_tx_gen_tx_byte_reg.sv
// Single-entry valid/ready output stage for the TX stream.
// It also records whether the held byte is a control character.
module tx_byte_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       load_ctrl,
    input  logic [7:0] load_data,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       holds_ctrl,
    output logic       load_ok
);

    // Free to take a new byte when empty, or when the held byte leaves this cycle.
    assign load_ok = !tx_valid || tx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            holds_ctrl <= 1'b0;
        end else if (load_ok) begin
            tx_valid   <= load;
            holds_ctrl <= load && load_ctrl;
            if (load) begin
                tx_data <= load_data;
            end
        end
    end

endmodule

// File: rtl/xon_xoff_tx_gen.sv
// XON/XOFF transmit generator: a hysteresis FSM on rx_level injects control chars ahead of user bytes.
// Define XOFF_RESEND_EN to build the periodic XOFF repeat while paused.
module xon_xoff_tx_gen
    import flow_ctrl_pkg::*;
#(
    parameter int LEVEL_W       = 5,
    parameter int HIGH_MARK     = 24,
    parameter int LOW_MARK      = 8,
    parameter int XON_ON_RESET  = 1,
    parameter int RESEND_PERIOD = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] rx_level,
    input  logic               remote_allow,
    xon_xoff_tx_gen_if.master  bus,
    output logic               local_paused,
    output logic               ctrl_busy
);

    localparam logic [LEVEL_W-1:0] HIGH_LVL = LEVEL_W'(HIGH_MARK);
    localparam logic [LEVEL_W-1:0] LOW_LVL  = LEVEL_W'(LOW_MARK);

    if (LOW_MARK >= HIGH_MARK) begin : g_bad_marks
        $error("xon_xoff_tx_gen: LOW_MARK must be below HIGH_MARK");
    end

    fc_state_t  state;
    logic       active;
    logic       ctrl_pending;
    logic       ctrl_load_state;
    logic [7:0] ctrl_char;
    logic       load_ok;
    logic       load_ctrl;
    logic       load_user;
    logic       holds_ctrl;

`ifdef XOFF_RESEND_EN
    if (RESEND_PERIOD < 2) begin : g_bad_period
        $error("xon_xoff_tx_gen: RESEND_PERIOD must be at least 2");
    end
    localparam int CNT_W = $clog2(RESEND_PERIOD);
    localparam logic [CNT_W-1:0] RESEND_LAST = CNT_W'(RESEND_PERIOD - 1);
    logic [CNT_W-1:0] resend_cnt;
`endif

    // INIT counts as pending so no user byte can slip out ahead of the reset XON.
    assign ctrl_load_state = (state == SEND_XOFF) || (state == SEND_XON);
    assign ctrl_pending    = ctrl_load_state || (state == INIT);
    assign ctrl_char       = (state == SEND_XOFF) ? XOFF_CHAR : XON_CHAR;
    assign ctrl_busy       = ctrl_pending || holds_ctrl;

    assign load_ctrl    = load_ok && ctrl_load_state;
    assign bus.in_ready = active && load_ok && !ctrl_pending && remote_allow;
    assign load_user    = bus.in_valid && bus.in_ready;

    tx_byte_reg u_tx_byte_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (load_ctrl || load_user),
        .load_ctrl  (load_ctrl),
        .load_data  (load_ctrl ? ctrl_char : bus.in_data),
        .tx_ready   (bus.tx_ready),
        .tx_data    (bus.tx_data),
        .tx_valid   (bus.tx_valid),
        .holds_ctrl (holds_ctrl),
        .load_ok    (load_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= (XON_ON_RESET != 0) ? INIT : RUN;
            local_paused <= 1'b0;
            active       <= 1'b0;
`ifdef XOFF_RESEND_EN
            resend_cnt   <= '0;
`endif
        end else begin
            active <= 1'b1;
`ifdef XOFF_RESEND_EN
            resend_cnt <= (state == PAUSED) ? resend_cnt + 1'b1 : '0;
`endif
            case (state)
                INIT: state <= SEND_XON;
                RUN: begin
                    if (rx_level >= HIGH_LVL) state <= SEND_XOFF;
                end
                SEND_XOFF: begin
                    if (load_ok) begin
                        state        <= PAUSED;
                        local_paused <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (rx_level <= LOW_LVL) state <= SEND_XON;
`ifdef XOFF_RESEND_EN
                    else if (resend_cnt == RESEND_LAST) state <= SEND_XOFF;
`endif
                end
                SEND_XON: begin
                    if (load_ok) begin
                        state        <= RUN;
                        local_paused <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_xon_xoff_tx_gen.sv
// Directed bench for xon_xoff_tx_gen: a cycle table for the main flow, then hand-written corner sequences.
module tb_xon_xoff_tx_gen;

    typedef struct {
        logic [4:0] rx;
        bit         allow;
        bit         iv;
        logic [7:0] d;
        bit         rdy;
        bit         e_ir;
        bit         e_tv;
        logic [7:0] e_td;
        bit         e_lp;
        bit         e_cb;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [4:0] rx_level;
    logic       remote_allow;
    logic       local_paused;
    logic       ctrl_busy;

    xon_xoff_tx_gen_if bus ();

    xon_xoff_tx_gen #(
        .LEVEL_W       (5),
        .HIGH_MARK     (24),
        .LOW_MARK      (8),
        .XON_ON_RESET  (1),
        .RESEND_PERIOD (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_level     (rx_level),
        .remote_allow (remote_allow),
        .bus          (bus),
        .local_paused (local_paused),
        .ctrl_busy    (ctrl_busy)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] sent[$];
    vec_t vec[15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Values stable at the falling edge are what the next rising edge sees.
    always @(negedge clk) begin
        if (!reset && bus.tx_valid && bus.tx_ready) sent.push_back(bus.tx_data);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk_seq(input string name, input int n,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] e[3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        chk({name, " count"}, sent.size(), n);
        for (int k = 0; k < n && k < 3; k++) begin
            if (k < sent.size()) chk($sformatf("%s byte%0d", name, k), sent[k], e[k]);
        end
    endtask

    task automatic drive(input logic [4:0] rx, input bit allow, input bit iv,
                         input logic [7:0] d, input bit rdy);
        rx_level       = rx;
        remote_allow   = allow;
        bus.in_valid   = iv;
        bus.in_data    = d;
        bus.tx_ready   = rdy;
    endtask

    initial begin
        int n13;
        vec[0]  = '{5'd0,  1, 1, 8'hA5, 1,  0, 0, 8'h00, 0, 1};
        vec[1]  = '{5'd0,  1, 1, 8'hA5, 1,  0, 0, 8'h00, 0, 1};
        vec[2]  = '{5'd0,  1, 1, 8'hA5, 1,  1, 1, 8'h11, 0, 1};
        vec[3]  = '{5'd0,  1, 1, 8'h5A, 1,  1, 1, 8'hA5, 0, 0};
        vec[4]  = '{5'd0,  1, 0, 8'h00, 1,  1, 1, 8'h5A, 0, 0};
        vec[5]  = '{5'd0,  1, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0};
        vec[6]  = '{5'd24, 1, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0};
        vec[7]  = '{5'd24, 1, 1, 8'h77, 1,  0, 0, 8'h00, 0, 1};
        vec[8]  = '{5'd15, 1, 1, 8'h77, 1,  1, 1, 8'h13, 1, 1};
        vec[9]  = '{5'd10, 1, 0, 8'h00, 1,  1, 1, 8'h77, 1, 0};
        vec[10] = '{5'd8,  1, 0, 8'h00, 1,  1, 0, 8'h00, 1, 0};
        vec[11] = '{5'd8,  1, 0, 8'h00, 1,  0, 0, 8'h00, 1, 1};
        vec[12] = '{5'd23, 1, 0, 8'h00, 1,  1, 1, 8'h11, 0, 1};
        vec[13] = '{5'd23, 1, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0};
        vec[14] = '{5'd23, 1, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0};

        reset = 1'b1;
        drive(5'd0, 1, 0, 8'h00, 1);
        ticks(2);
        @(negedge clk);
        chk("reset tx_valid", bus.tx_valid, 0);
        chk("reset tx_data", bus.tx_data, 0);
        chk("reset in_ready", bus.in_ready, 0);
        chk("reset local_paused", local_paused, 0);
        chk("reset ctrl_busy", ctrl_busy, 1);

        tick();
        reset = 1'b0;
        sent.delete();
        for (int i = 0; i < 15; i++) begin
            drive(vec[i].rx, vec[i].allow, vec[i].iv, vec[i].d, vec[i].rdy);
            @(negedge clk);
            chk($sformatf("row%0d in_ready", i), bus.in_ready, vec[i].e_ir);
            chk($sformatf("row%0d tx_valid", i), bus.tx_valid, vec[i].e_tv);
            if (vec[i].e_tv) chk($sformatf("row%0d tx_data", i), bus.tx_data, vec[i].e_td);
            chk($sformatf("row%0d local_paused", i), local_paused, vec[i].e_lp);
            chk($sformatf("row%0d ctrl_busy", i), ctrl_busy, vec[i].e_cb);
            tick();
        end
        chk("table stream count", sent.size(), 6);
        if (sent.size() == 6) begin
            chk("table s0", sent[0], 8'h11);
            chk("table s1", sent[1], 8'hA5);
            chk("table s2", sent[2], 8'h5A);
            chk("table s3", sent[3], 8'h13);
            chk("table s4", sent[4], 8'h77);
            chk("table s5", sent[5], 8'h11);
        end

        // User bytes matching the control codes pass untouched and do not pause.
        sent.delete();
        drive(5'd0, 1, 1, 8'h11, 1); tick();
        drive(5'd0, 1, 1, 8'h13, 1); tick();
        drive(5'd0, 1, 0, 8'h00, 1); ticks(3);
        chk_seq("passthru", 2, 8'h11, 8'h13, 8'h00);
        chk("passthru local_paused", local_paused, 0);

        // XOFF becomes due while a user byte is stalled in the output register.
        sent.delete();
        drive(5'd0, 1, 1, 8'h42, 0); tick();
        drive(5'd30, 1, 0, 8'h00, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("held%0d tx_valid", k), bus.tx_valid, 1);
            chk($sformatf("held%0d tx_data", k), bus.tx_data, 8'h42);
            tick();
        end
        drive(5'd30, 1, 1, 8'h99, 1);
        @(negedge clk);
        chk("held xoff pending in_ready", bus.in_ready, 0);
        chk("held xoff pending ctrl_busy", ctrl_busy, 1);
        tick();
        drive(5'd30, 1, 0, 8'h00, 1);
        @(negedge clk);
        chk("held xoff tx_data", bus.tx_data, 8'h13);
        ticks(3);
        chk_seq("held order", 2, 8'h42, 8'h13, 8'h00);
        chk("held local_paused", local_paused, 1);
        drive(5'd0, 1, 0, 8'h00, 1); ticks(5);

        // remote_allow low blocks user data but not XOFF/XON.
        sent.delete();
        drive(5'd30, 0, 1, 8'h55, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("blocked%0d in_ready", k), bus.in_ready, 0);
            tick();
        end
        chk_seq("blocked xoff", 1, 8'h13, 8'h00, 8'h00);
        chk("blocked local_paused", local_paused, 1);
        drive(5'd0, 0, 1, 8'h55, 1); ticks(5);
        chk_seq("blocked xon", 2, 8'h13, 8'h11, 8'h00);
        drive(5'd0, 1, 1, 8'h55, 1); tick();
        drive(5'd0, 1, 0, 8'h00, 1); ticks(3);
        chk_seq("unblocked", 3, 8'h13, 8'h11, 8'h55);

        // remote_allow drops while a user byte is held: it still completes, nothing follows.
        sent.delete();
        drive(5'd0, 1, 1, 8'h42, 0); tick();
        drive(5'd0, 0, 1, 8'h66, 0);
        @(negedge clk);
        chk("allowdrop in_ready", bus.in_ready, 0);
        chk("allowdrop tx_valid", bus.tx_valid, 1);
        ticks(2);
        drive(5'd0, 0, 1, 8'h66, 1); ticks(4);
        chk_seq("allowdrop", 1, 8'h42, 8'h00, 8'h00);
        chk("allowdrop drained", bus.tx_valid, 0);
        drive(5'd0, 1, 0, 8'h00, 1);

        // Steady high level while paused: XOFF repeats only with the resend feature.
        sent.delete();
        drive(5'd30, 1, 0, 8'h00, 1); ticks(60);
        n13 = 0;
        foreach (sent[k]) if (sent[k] == 8'h13) n13++;
`ifdef XOFF_RESEND_EN
        chk("resend xoff count", n13, 4);
`else
        chk("single xoff count", n13, 1);
`endif
        chk("resend local_paused", local_paused, 1);
        drive(5'd0, 1, 0, 8'h00, 1); ticks(5);
        chk("resume local_paused", local_paused, 0);

        // Asynchronous reset discards a held byte immediately.
        drive(5'd0, 1, 1, 8'h42, 0); tick();
        drive(5'd0, 1, 0, 8'h00, 0);
        @(negedge clk);
        chk("prereset tx_valid", bus.tx_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("async reset tx_valid", bus.tx_valid, 0);
        chk("async reset ctrl_busy", ctrl_busy, 1);
        chk("async reset local_paused", local_paused, 0);
        tick();
        reset = 1'b0;
        sent.delete();
        drive(5'd0, 1, 0, 8'h00, 1); ticks(5);
        chk_seq("post reset xon", 1, 8'h11, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xon_xoff_tx_gen.md
Name: xon_xoff_tx_gen

Overview:
Transmit-side XON/XOFF generator. It watches the local receive-buffer fill level and injects XOFF/XON control characters into the outgoing byte stream with hysteresis, so the remote end pauses and resumes. It sits between the user TX byte source and the UART transmitter, and arbitrates control characters over user data. It also honours remote_allow from the receive-side flow-control decoder, which gates user data only.

Parameters:
LEVEL_W, 5, width of rx_level (receive buffer depth up to 2**LEVEL_W-1)
HIGH_MARK, 24, rx_level >= HIGH_MARK triggers XOFF
LOW_MARK, 8, rx_level <= LOW_MARK triggers XON; LOW_MARK < HIGH_MARK is checked at elaboration
XON_ON_RESET, 1, 1 = send one XON after reset so the remote cannot stay stuck paused
RESEND_PERIOD, 1024, cycles between XOFF repeats (used only with the optional feature)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
rx_level  input  LEVEL_W  current local receive-buffer occupancy
remote_allow  input  1  1 = remote accepts data (from the receive-side decoder)
in_data  input  8  user byte
in_valid  input  1  user byte valid
in_ready  output  1  user byte accepted when in_valid && in_ready
tx_data  output  8  byte to UART TX
tx_valid  output  1  tx_data valid
tx_ready  input  1  UART TX accepts when tx_valid && tx_ready
local_paused  output  1  1 = XOFF sent and XON not yet sent
ctrl_busy  output  1  1 = a control char is pending or held in the output register

Behaviour:
- Reset values: tx_valid=0, tx_data=0, in_ready=0, local_paused=0, ctrl_busy=XON_ON_RESET. State is INIT if XON_ON_RESET=1, otherwise RUN.
- Output register: a single byte stage. It loads when empty or when the current byte is accepted (tx_valid && tx_ready) in the same cycle. Once tx_valid is asserted, tx_data is held stable until accepted. Control chars never preempt a held byte.
- Load priority: pending control char first, then user byte. User bytes require remote_allow=1. Control chars are sent regardless of remote_allow.
- in_ready = load_ok && !ctrl_pending && remote_allow. This is combinational from registered state, remote_allow and tx_ready.
- Latency: a user byte accepted in cycle N appears with tx_valid in cycle N+1.
- FSM states:
  - INIT: ctrl_pending=XON → SEND_XON.
  - RUN: rx_level >= HIGH_MARK → SEND_XOFF.
  - SEND_XOFF: XOFF (8'h13) pending. On load into the output register → PAUSED, and local_paused=1 the same edge.
  - PAUSED: rx_level <= LOW_MARK → SEND_XON.
  - SEND_XON: XON (8'h11) pending. On load → RUN, and local_paused=0.
- Levels between the marks cause no transition (hysteresis).
- rx_level falling below LOW_MARK before XOFF is loaded: XOFF is still sent, then XON. There is no cancellation.
- User bytes equal to 8'h11 or 8'h13 pass through unmodified. Escaping is out of scope.
- remote_allow dropping while a user byte is held: that byte still completes. No further user bytes load.
- Reset mid-transfer: the held byte is discarded and tx_valid drops asynchronously.
- ctrl_busy = (state in INIT/SEND_XOFF/SEND_XON) || the output register holds a control char.

Optional Feature:
XOFF_RESEND_EN
- With the macro: a counter runs in PAUSED and clears on entry. When it reaches RESEND_PERIOD-1 and rx_level > LOW_MARK, the FSM returns to SEND_XOFF and retransmits XOFF; local_paused stays 1. This recovers a lost XOFF.
- Without the macro: no counter is built, RESEND_PERIOD is ignored, and PAUSED exits only via LOW_MARK.

Decomposition:
- Package flow_ctrl_pkg holds XON_CHAR=8'h11, XOFF_CHAR=8'h13, and the FSM state enum (INIT, RUN, SEND_XOFF, PAUSED, SEND_XON). The existing receive-side decoder migrates to the same constants.
- One sub-module, tx_byte_reg: the single-entry valid/ready output stage with a "holds control" flag. The FSM and arbitration stay in the top module.

Test Plan:
- Reset with XON_ON_RESET=1, tx_ready=1 → first tx byte is 8'h11; local_paused=0; then user bytes 8'hA5, 8'h5A follow in order, each one cycle after acceptance.
- rx_level ramps 0→24 while user streams with tx_ready=1 → exactly one 8'h13 injected before the next user byte; local_paused=1; level at 10..23 causes no further control chars.
- rx_level drops to 8 while PAUSED → one 8'h11 sent; local_paused=0; level back at 23 sends nothing.
- XOFF needed while 8'h42 is held with tx_ready=0 for 5 cycles → 8'h42 is stable and accepted first, then 8'h13; in_ready=0 while XOFF is pending.
- remote_allow=0 with in_valid=1 and rx_level=30 → in_ready=0, user data is blocked, but 8'h13 is still transmitted.
- With XOFF_RESEND_EN, RESEND_PERIOD=16, rx_level held at 30 → 8'h13 repeats every 16 cycles in PAUSED (plus send latency). Without the macro, only one 8'h13 is sent.
